// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/grant/data bundle between requesters and the round-robin mux arbiter
interface rr_mux_arbiter_if #(
  parameter int N = 5
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  w;
  logic [SW-1:0] sel;
  logic [N-1:0]  gnt;
  logic          out;
  logic          out_valid;
  logic          busy;

  modport master (output req, w, input sel, gnt, out, out_valid, busy);
  modport slave  (input req, w, output sel, gnt, out, out_valid, busy);
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving an N:1 bit mux select with a per-grant hold cap
module rr_mux_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int              SW       = (N > 1) ? $clog2(N) : 1;
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [SW-1:0]   LAST     = SW'(N - 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE = HW'(1);
  localparam logic [N-1:0]    ONE_HOT0 = N'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic [SW-1:0] sel_nxt;
  logic [SW-1:0] base;
  logic [SW-1:0] pick;
  logic          found;
  logic          release_grant;

  assign sel_nxt       = (sel_q == LAST) ? '0 : sel_q + 1'b1;
  assign release_grant = !bus.req[sel_q] || (hold_q == HOLD_MAX);
  // on release the search starts just past the owner, so the owner is considered last
  assign base          = (state_q == BUSY) ? sel_nxt : ptr_q;

  always_comb begin
    logic [SW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = base;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    hold_d      = hold_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          sel_d   = pick;
          gnt_d   = ONE_HOT0 << pick;
          hold_d  = HOLD_ONE;
        end
      end
      BUSY: begin
        out_d       = bus.w[sel_q];
        out_valid_d = bus.req[sel_q];
        if (!release_grant) begin
          hold_d = hold_q + 1'b1;
        end else begin
          ptr_d = sel_nxt;
          if (found) begin
            sel_d  = pick;
            gnt_d  = ONE_HOT0 << pick;
            hold_d = HOLD_ONE;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      hold_q      <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == BUSY);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed bench for rr_mux_arbiter with a grant-level reference model
module tb_rr_mux_arbiter;
  localparam int N        = 5;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(N)) bus ();
  rr_mux_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

  // reference model: who owns the mux, for how long, and where the next search begins
  logic m_busy;
  int   m_owner, m_cnt, m_ptr;
  logic m_out, m_ov;
  int   pick_idle, pick_rel;

  function automatic int first_req(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always_comb pick_idle = first_req(m_ptr, bus.req);
  always_comb pick_rel  = first_req((m_owner + 1) % N, bus.req);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_cnt <= 0; m_ptr <= 0; m_out <= 1'b0; m_ov <= 1'b0;
    end else if (!m_busy) begin
      m_ov <= 1'b0;
      if (pick_idle >= 0) begin
        m_busy <= 1'b1; m_owner <= pick_idle; m_cnt <= 1;
      end
    end else begin
      m_out <= bus.w[m_owner];
      m_ov  <= bus.req[m_owner];
      if (bus.req[m_owner] && m_cnt < MAX_HOLD) begin
        m_cnt <= m_cnt + 1;
      end else begin
        m_ptr <= (m_owner + 1) % N;
        if (pick_rel >= 0) begin
          m_owner <= pick_rel; m_cnt <= 1;
        end else begin
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
      if (m_busy) check("sel", 32'(bus.sel), 32'(m_owner));
      check("out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("out", 32'(bus.out), 32'(m_out));
      check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("sel_range", 32'(bus.sel < N), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  int exp3 [20] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4};
  int exp4 [9]  = '{0,0,0,0,1,1,1,1,0};
  int gnt_cycles, ov_cycles;

  initial begin
    // reset and idle
    rst = 1'b1; bus.req = 5'b11111; bus.w = 5'b00000;
    #3;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    step();
    rst = 1'b0; bus.req = 5'b00000;
    for (int i = 0; i < 5; i++) step();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_gnt", 32'(bus.gnt), 32'd0);

    // single requester keeps the grant across hold expiries
    bus.req = 5'b00100; bus.w = 5'b00100;
    for (int i = 0; i < 12; i++) begin
      step();
      check("single_gnt", 32'(bus.gnt), 32'b00100);
      check("single_sel", 32'(bus.sel), 32'd2);
      check("single_ov", 32'(bus.out_valid), (i >= 1) ? 32'd1 : 32'd0);
      if (i >= 1) check("single_out", 32'(bus.out), 32'd1);
    end
    bus.req = 5'b00000;
    step();
    check("single_release", 32'(bus.busy), 32'd0);
    pulse_reset();

    // full contention, then wrap-around onto 0 and 1
    bus.req = 5'b11111; bus.w = 5'b10101;
    for (int i = 0; i < 20; i++) begin
      step();
      check("rr_sel", 32'(bus.sel), 32'(exp3[i]));
      check("rr_busy", 32'(bus.busy), 32'd1);
    end
    bus.req = 5'b00011;
    for (int i = 0; i < 9; i++) begin
      step();
      check("wrap_sel", 32'(bus.sel), 32'(exp4[i]));
    end
    bus.req = 5'b00000;
    step();
    step();

    // early release by requester 1, then requester 3
    bus.req = 5'b00010; bus.w = 5'b11111;
    gnt_cycles = 0; ov_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.req = 5'b00000;
      step();
      if (bus.gnt == 5'b00010) gnt_cycles++;
      if (bus.out_valid) ov_cycles++;
    end
    check("early_gnt_cycles", 32'(gnt_cycles), 32'd3);
    check("early_ov_cycles", 32'(ov_cycles), 32'd2);
    check("early_busy", 32'(bus.busy), 32'd0);
    check("early_gnt", 32'(bus.gnt), 32'd0);
    bus.req = 5'b01000;
    step();
    check("next_gnt", 32'(bus.gnt), 32'b01000);
    check("next_sel", 32'(bus.sel), 32'd3);

    // asynchronous reset in the middle of a grant
    bus.req = 5'b11111;
    step();
    step();
    check("pre_rst_gnt", 32'(bus.gnt), 32'b01000);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_sel", 32'(bus.sel), 32'd0);
    check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_gnt", 32'(bus.gnt), 32'b00001);
    check("post_rst_sel", 32'(bus.sel), 32'd0);
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
